// File: rtl/simon_decrypt.sv
// Iterative SIMON32/64 decryption core: expands the 64-bit master key into a round-key store, then
// runs the inverse Feistel rounds in reverse key order. Optional key cache: SIMON_DEC_KEY_CACHE_EN.
module simon_decrypt #(
   parameter int          ROUNDS = 32,
   parameter logic [61:0] Z0     = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] key,
   input  logic [31:0] cipher_text,
   output logic [31:0] plain_text,
   output logic        done,
   output logic        busy
);

   localparam int IDX_W = $clog2(ROUNDS);
   localparam logic [IDX_W-1:0] FIRST_GEN = IDX_W'(4);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, KEYGEN, DEC, DONE} state_t;

   state_t           state;
   logic [15:0]      x;
   logic [15:0]      y;
   logic [IDX_W-1:0] idx;
   logic [15:0]      ks [ROUNDS];

   logic [15:0] gen_t;
   logic [15:0] gen_k;
   logic [15:0] y_new;
   logic        key_hit;

   function automatic logic [15:0] ror16(input logic [15:0] v, input int unsigned n);
      return (v >> n) | (v << (16 - n));
   endfunction

   function automatic logic [15:0] rol16(input logic [15:0] v, input int unsigned n);
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic logic [15:0] simon_f(input logic [15:0] v);
      return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
   endfunction

   // Element j of the z0 sequence sits at bit 61-j (leftmost character is element 0).
   function automatic logic z0_bit(input logic [IDX_W-1:0] i);
      int         j;
      logic [5:0] j6;
      j  = (int'(i) - 4) % 62;
      j6 = 6'(j);
      return Z0[6'd61 - j6];
   endfunction

   always_comb begin
      gen_t = ror16(ks[idx - IDX_W'(1)], 3) ^ ks[idx - IDX_W'(3)];
      gen_k = ~ks[idx - IDX_W'(4)] ^ gen_t ^ ror16(gen_t, 1) ^ {15'b0, z0_bit(idx)} ^ 16'h0003;
      y_new = x ^ simon_f(y) ^ ks[idx];
   end

`ifdef SIMON_DEC_KEY_CACHE_EN
   logic [63:0] cached_key;
   logic        cache_valid;
   assign key_hit = cache_valid && (key == cached_key);
`else
   assign key_hit = 1'b0;
`endif

   // Key store and cached key are pure data: no reset, contents qualified by state / cache_valid.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         ks[0] <= key[15:0];
         ks[1] <= key[31:16];
         ks[2] <= key[47:32];
         ks[3] <= key[63:48];
`ifdef SIMON_DEC_KEY_CACHE_EN
         if (!key_hit)
            cached_key <= key;
`endif
      end else if (state == KEYGEN) begin
         ks[idx] <= gen_k;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         idx        <= '0;
         plain_text <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
`ifdef SIMON_DEC_KEY_CACHE_EN
         cache_valid <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  x    <= cipher_text[31:16];
                  y    <= cipher_text[15:0];
                  busy <= 1'b1;
                  if (key_hit) begin
                     idx   <= LAST_IDX;
                     state <= DEC;
                  end else begin
                     idx   <= FIRST_GEN;
                     state <= KEYGEN;
`ifdef SIMON_DEC_KEY_CACHE_EN
                     // Store is about to be overwritten; invalidate until expansion completes.
                     cache_valid <= 1'b0;
`endif
                  end
               end
            end
            KEYGEN: begin
               if (idx == LAST_IDX) begin
                  state <= DEC;
`ifdef SIMON_DEC_KEY_CACHE_EN
                  cache_valid <= 1'b1;
`endif
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DEC: begin
               x   <= y;
               y   <= y_new;
               idx <= idx - IDX_W'(1);
               if (idx == '0) begin
                  plain_text <= {y, y_new};
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simon_decrypt.sv
// Directed bench for simon_decrypt: published vector, ignored restarts, reset abort,
// back-to-back operation and encrypt/decrypt round trips (optional key-cache latency).
module tb_simon_decrypt;

   localparam int FULL_LAT = 60;
   localparam int HIT_LAT  = 32;
   localparam logic [63:0] PUB_KEY = 64'h1918111009080100;
   localparam logic [31:0] PUB_CT  = 32'hc69be9bb;
   localparam logic [31:0] PUB_PT  = 32'h65656877;

   logic        clk;
   logic        reset;
   logic        start;
   logic [63:0] key;
   logic [31:0] cipher_text;
   logic [31:0] plain_text;
   logic        done;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

`ifdef SIMON_DEC_KEY_CACHE_EN
   bit          m_valid = 0;
   logic [63:0] m_key   = '0;
`endif

   simon_decrypt dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .key         (key),
      .cipher_text (cipher_text),
      .plain_text  (plain_text),
      .done        (done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
      return (v >> n) | (v << (16 - n));
   endfunction

   function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
      return (v << n) | (v >> (16 - n));
   endfunction

   // Forward SIMON32/64 encryption, used to produce ciphertexts for round trips.
   function automatic logic [31:0] encrypt(input logic [63:0] k, input logic [31:0] p);
      logic [61:0] z;
      logic [15:0] ks [32];
      logic [15:0] t, a, b, tmp;
      z = 62'b11111010001001010110000111001101111101000100101011000011100110;
      ks[0] = k[15:0];  ks[1] = k[31:16];
      ks[2] = k[47:32]; ks[3] = k[63:48];
      for (int i = 4; i < 32; i++) begin
         t = ror16(ks[i-1], 3) ^ ks[i-3];
         ks[i] = ~ks[i-4] ^ t ^ ror16(t, 1) ^ {15'b0, z[61-(i-4)]} ^ 16'h0003;
      end
      a = p[31:16];
      b = p[15:0];
      for (int i = 0; i < 32; i++) begin
         tmp = a;
         a = b ^ ((rol16(a, 1) & rol16(a, 8)) ^ rol16(a, 2)) ^ ks[i];
         b = tmp;
      end
      return {a, b};
   endfunction

   function automatic int exp_lat(input logic [63:0] k);
      int lat;
      lat = FULL_LAT;
`ifdef SIMON_DEC_KEY_CACHE_EN
      if (m_valid && k == m_key) lat = HIT_LAT;
`endif
      return lat;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
`ifdef SIMON_DEC_KEY_CACHE_EN
      m_valid = 0;
`endif
   endtask

   // One decryption; pa/pb are extra start pulses sampled at edge E<pa>/E<pb> (0 = none).
   // stop_at_done returns right after the done edge instead of observing a fixed window.
   task automatic run_dec(input logic [63:0] k, input logic [31:0] ct, input logic [31:0] exp_pt,
                          input string tag, input int pa, input int pb, input bit stop_at_done);
      int          lat, first, dones, limit;
      bit          held_ok;
      logic [31:0] held;
      lat     = exp_lat(k);
      held    = plain_text;
      held_ok = 1;
      dones   = 0;
      first   = -1;
      limit   = stop_at_done ? 200 : 70;
      @(negedge clk);
      key = k; cipher_text = ct; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key = ~k; cipher_text = ~ct;
      check({tag, "/busy_e0"}, 64'(busy), 64'(1));
      for (int n = 1; n <= limit; n++) begin
         start = (n == pa || n == pb);
         @(posedge clk); #1;
         if (done) begin
            dones++;
            if (first < 0) first = n;
         end else if (first < 0 && plain_text !== held) begin
            held_ok = 0;
         end
         if (stop_at_done && first >= 0) break;
      end
      start = 1'b0;
      check({tag, "/latency"}, 64'(first), 64'(lat));
      check({tag, "/plain"}, 64'(plain_text), 64'(exp_pt));
      check({tag, "/held"}, 64'(held_ok), 64'(1));
      check({tag, "/busy_end"}, 64'(busy), 64'(0));
      if (!stop_at_done) begin
         check({tag, "/done_count"}, 64'(dones), 64'(1));
         check({tag, "/done_end"}, 64'(done), 64'(0));
      end
`ifdef SIMON_DEC_KEY_CACHE_EN
      if (first >= 0) begin
         m_valid = 1;
         m_key   = k;
      end
`endif
   endtask

   initial begin
      logic [63:0] k;
      logic [31:0] p;
      int          dones;
      logic [63:0] dir_key [3];
      logic [31:0] dir_pt  [3];

      reset = 1'b1; start = 1'b0; key = '0; cipher_text = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/plain", 64'(plain_text), 64'(0));
      check("reset/done",  64'(done),       64'(0));
      check("reset/busy",  64'(busy),       64'(0));
      @(negedge clk); reset = 1'b0;

      run_dec(PUB_KEY, PUB_CT, PUB_PT, "pub", 0, 0, 0);

      do_reset();
      #1;
      check("reset2/plain", 64'(plain_text), 64'(0));
      run_dec(PUB_KEY, PUB_CT, PUB_PT, "repulse", 10, 40, 0);

      // Abort mid-decryption: outputs clear immediately and no done appears.
      @(negedge clk);
      key = PUB_KEY; cipher_text = PUB_CT; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (35) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort/plain", 64'(plain_text), 64'(0));
      check("abort/busy",  64'(busy),       64'(0));
      check("abort/done",  64'(done),       64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
`ifdef SIMON_DEC_KEY_CACHE_EN
      m_valid = 0;
`endif
      dones = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort/no_done", 64'(dones), 64'(0));
      check("abort/idle_busy", 64'(busy), 64'(0));
      run_dec(PUB_KEY, PUB_CT, PUB_PT, "fresh", 0, 0, 0);

      // Back-to-back: second start lands in the cycle after done.
      k = 64'h0123456789abcdef;
      p = 32'h0badcafe;
      run_dec(PUB_KEY, PUB_CT, PUB_PT, "b2b1", 0, 0, 1);
      @(posedge clk);
      run_dec(k, encrypt(k, p), p, "b2b2", 0, 0, 0);

      dir_key[0] = PUB_KEY;             dir_pt[0] = PUB_PT;
      dir_key[1] = 64'h0000000000000000; dir_pt[1] = 32'h00000000;
      dir_key[2] = 64'hffffffffffffffff; dir_pt[2] = 32'hffffffff;
      for (int i = 0; i < 3; i++)
         run_dec(dir_key[i], encrypt(dir_key[i], dir_pt[i]), dir_pt[i], $sformatf("rt_dir%0d", i), 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         k = {$urandom, $urandom};
         p = $urandom;
         run_dec(k, encrypt(k, p), p, $sformatf("rt_rand%0d", i), 0, 0, 0);
      end

`ifdef SIMON_DEC_KEY_CACHE_EN
      do_reset();
      k = 64'h0f1e2d3c4b5a6978;
      p = 32'h13572468;
      run_dec(k, encrypt(k, p), p, "cache_miss", 0, 0, 0);
      run_dec(k, encrypt(k, ~p), ~p, "cache_hit", 0, 0, 0);
      run_dec(PUB_KEY, PUB_CT, PUB_PT, "cache_newkey", 0, 0, 0);
      do_reset();
      run_dec(PUB_KEY, PUB_CT, PUB_PT, "cache_after_rst", 0, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
